// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the IF stage: next-PC select encodings, reset PC
// default and a word-alignment helper.
package fetch_stage_pkg;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
    localparam int          IM_AW_DEFAULT    = 10;

    typedef enum logic [1:0] {
        NPC_SEQ = 2'b00,
        NPC_BR  = 2'b01,
        NPC_J   = 2'b10,
        NPC_JR  = 2'b11
    } npc_sel_e;

    // Every PC that gets loaded is word aligned.
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & ~32'd3;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// IF-stage bus: D-stage redirect/hazard controls and IM read data in,
// fetch PC, IM address and IF/ID latch contents out.
interface fetch_stage_if #(
    parameter int IM_AW = 10
);
    logic             stall;
    logic [1:0]       npc_sel;
    logic             br_taken;
    logic [31:0]      br_target;
    logic [31:0]      j_target;
    logic [31:0]      jr_target;
    logic [31:0]      instr_f;
    logic [31:0]      pc_f;
    logic [IM_AW-1:0] im_addr;
    logic [31:0]      instr_d;
    logic [31:0]      pc_d;
    logic [31:0]      pc8_d;
    logic             valid_d;

    // Rest of the pipeline (hazard unit, D-stage control, IM).
    modport master (
        output stall, npc_sel, br_taken, br_target, j_target, jr_target, instr_f,
        input  pc_f, im_addr, instr_d, pc_d, pc8_d, valid_d
    );

    // The fetch stage itself.
    modport slave (
        input  stall, npc_sel, br_taken, br_target, j_target, jr_target, instr_f,
        output pc_f, im_addr, instr_d, pc_d, pc8_d, valid_d
    );
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline latch with stall (hold) enable and asynchronous reset.
module fetch_stage_if_id_reg #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] instr_f,
    input  logic [31:0] pc_f,
    input  logic [31:0] pc8_f,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc8_d,
    output logic        valid_d
);
    // Capture the fetched word unless the hazard unit holds the pipe.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: async reset returns the latch to a nop so D sees a harmless word.
        if (reset) begin
            instr_d <= 32'd0;
            pc_d    <= PC_RESET;
            pc8_d   <= PC_RESET + 32'd8;
            valid_d <= 1'b0;
        end else if (!stall) begin
            // NOTE: non-blocking so all IF/ID fields update together at the edge.
            instr_d <= instr_f;
            pc_d    <= pc_f;
            pc8_d   <= pc8_f;
            valid_d <= 1'b1;
        end
    end
endmodule

// File: rtl/fetch_stage_npc_mux.sv
// Combinational next-PC select from the sequential, branch, jump and
// register-jump sources resolved in the D stage.
module fetch_stage_npc_mux
    import fetch_stage_pkg::*;
(
    input  logic [31:0] pc_f,
    input  logic [1:0]  npc_sel,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic [31:0] j_target,
    input  logic [31:0] jr_target,
    output logic [31:0] npc
);
    logic [31:0] npc_raw;

    // Pick the raw next PC; sequential fetch is the fallback.
    always_comb begin
        // NOTE: default first so every path assigns npc_raw and no latch is inferred.
        npc_raw = pc_f + 32'd4;
        case (npc_sel_e'(npc_sel))
            NPC_SEQ: npc_raw = pc_f + 32'd4;
            NPC_BR:  if (br_taken) npc_raw = br_target;
            NPC_J:   npc_raw = j_target;
            NPC_JR:  npc_raw = jr_target;
            default: npc_raw = pc_f + 32'd4;
        endcase
    end

    assign npc = word_align(npc_raw);
endmodule

// File: rtl/fetch_stage.sv
// IF stage of the five-stage MIPS pipeline: PC register, IM addressing,
// next-PC selection and the IF/ID latch. Branch delay slot is architectural,
// so there is no flush path.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
    parameter int          IM_AW    = IM_AW_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.slave  bus
);
    logic [31:0] pc_f;
    logic [31:0] npc;

    fetch_stage_npc_mux u_npc_mux (
        .pc_f      (pc_f),
        .npc_sel   (bus.npc_sel),
        .br_taken  (bus.br_taken),
        .br_target (bus.br_target),
        .j_target  (bus.j_target),
        .jr_target (bus.jr_target),
        .npc       (npc)
    );

    // PC register: advance to the selected next PC unless stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)           pc_f <= PC_RESET;
        else if (!bus.stall) pc_f <= npc;
    end

    fetch_stage_if_id_reg #(.PC_RESET(PC_RESET)) u_if_id (
        .clk     (clk),
        .reset   (reset),
        .stall   (bus.stall),
        .instr_f (bus.instr_f),
        .pc_f    (pc_f),
        .pc8_f   (pc_f + 32'd8),
        .instr_d (bus.instr_d),
        .pc_d    (bus.pc_d),
        .pc8_d   (bus.pc8_d),
        .valid_d (bus.valid_d)
    );

    // Word index relative to the IM base; out-of-range PCs wrap modulo 2^IM_AW.
    assign bus.im_addr = IM_AW'((pc_f - PC_RESET) >> 2);
    assign bus.pc_f    = pc_f;
endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus pushes the expected post-edge
// state from a reference model; a monitor pops and compares after each edge.
module tb_fetch_stage;
    localparam logic [31:0] PCR = 32'h0000_3000;
    localparam int          AW  = 10;

    typedef struct {
        logic [31:0] pc_f;
        logic [31:0] im_addr;
        logic [31:0] instr_d;
        logic [31:0] pc_d;
        logic [31:0] pc8_d;
        logic [31:0] valid_d;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    exp_t        exp_q[$];
    logic [31:0] imem [0:(1<<AW)-1];

    // Reference model state.
    logic [31:0] m_pc, m_instr, m_pcd, m_pc8;
    logic        m_valid;

    fetch_stage_if #(.IM_AW(AW)) bus ();

    fetch_stage #(.PC_RESET(PCR), .IM_AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    assign bus.instr_f = imem[bus.im_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] idx_of(input logic [31:0] pc);
        return ((pc - PCR) >> 2) % (1 << AW);
    endfunction

    task automatic model_reset();
        m_pc = PCR; m_instr = 0; m_pcd = PCR; m_pc8 = PCR + 8; m_valid = 0;
    endtask

    task automatic model_step(input bit st, input logic [1:0] sel, input bit tk,
                              input logic [31:0] bt, jt, jrt);
        logic [31:0] n;
        if (st) return;
        case (sel)
            2'd0: n = m_pc + 4;
            2'd1: n = tk ? bt : m_pc + 4;
            2'd2: n = jt;
            default: n = jrt;
        endcase
        n = (n / 4) * 4;
        m_instr = imem[idx_of(m_pc)];
        m_pcd   = m_pc;
        m_pc8   = m_pc + 8;
        m_valid = 1;
        m_pc    = n;
    endtask

    // One clock: drive at the falling edge, optionally pulse or hold reset,
    // and push the state expected after the following rising edge.
    task automatic cycle(input bit rst_hold, input bit rst_pulse, input bit st,
                         input logic [1:0] sel, input bit tk,
                         input logic [31:0] bt, jt, jrt);
        exp_t e;
        @(negedge clk);
        if (rst_pulse) begin
            #1 reset = 1'b1;
            #1;
            check("pulse_pc_f",    bus.pc_f,    PCR);
            check("pulse_instr_d", bus.instr_d, 32'd0);
            check("pulse_valid_d", {31'd0, bus.valid_d}, 32'd0);
            check("pulse_pc_d",    bus.pc_d,    PCR);
            check("pulse_pc8_d",   bus.pc8_d,   PCR + 8);
            reset = 1'b0;
            model_reset();
        end
        reset         = rst_hold;
        bus.stall     = st;
        bus.npc_sel   = sel;
        bus.br_taken  = tk;
        bus.br_target = bt;
        bus.j_target  = jt;
        bus.jr_target = jrt;
        if (rst_hold) model_reset();
        else          model_step(st, sel, tk, bt, jt, jrt);
        e.pc_f = m_pc; e.im_addr = idx_of(m_pc); e.instr_d = m_instr;
        e.pc_d = m_pcd; e.pc8_d = m_pc8; e.valid_d = {31'd0, m_valid};
        exp_q.push_back(e);
    endtask

    // Monitor: compare DUT outputs against the oldest expectation after each edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("pc_f",    bus.pc_f,                e.pc_f);
            check("im_addr", {22'd0, bus.im_addr},    e.im_addr);
            check("instr_d", bus.instr_d,             e.instr_d);
            check("pc_d",    bus.pc_d,                e.pc_d);
            check("pc8_d",   bus.pc8_d,               e.pc8_d);
            check("valid_d", {31'd0, bus.valid_d},    e.valid_d);
        end
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) imem[i] = $urandom;
        reset = 1'b1;
        bus.stall = 0; bus.npc_sel = 0; bus.br_taken = 0;
        bus.br_target = 0; bus.j_target = 0; bus.jr_target = 0;
        model_reset();

        // Reset held over an edge, then a few sequential fetches.
        cycle(1, 0, 0, 2'd0, 0, 0, 0, 0);
        cycle(0, 0, 0, 2'd0, 0, 0, 0, 0);
        cycle(0, 0, 0, 2'd0, 0, 0, 0, 0);
        cycle(0, 0, 0, 2'd0, 0, 0, 0, 0);
        // Mid-cycle reset pulse, then seq to 0x3008 and a taken branch.
        cycle(0, 1, 0, 2'd0, 0, 0, 0, 0);
        cycle(0, 0, 0, 2'd0, 0, 0, 0, 0);
        cycle(0, 0, 0, 2'd1, 1, 32'h3040, 0, 0);
        // Not-taken branch at 0x3008.
        cycle(0, 1, 0, 2'd0, 0, 0, 0, 0);
        cycle(0, 0, 0, 2'd0, 0, 0, 0, 0);
        cycle(0, 0, 0, 2'd1, 0, 32'h3040, 0, 0);
        // Stall wins over a jump for two edges, then the jump lands.
        cycle(0, 0, 1, 2'd2, 0, 0, 32'h3100, 0);
        cycle(0, 0, 1, 2'd2, 0, 0, 32'h3100, 0);
        cycle(0, 0, 0, 2'd2, 0, 0, 32'h3100, 0);
        cycle(0, 0, 0, 2'd0, 0, 0, 0, 0);
        // jr alignment and 32-bit wrap of the sequential PC.
        cycle(0, 0, 0, 2'd3, 0, 0, 0, 32'h3013);
        cycle(0, 0, 0, 2'd3, 0, 0, 0, 32'hFFFF_FFFF);
        cycle(0, 0, 0, 2'd0, 0, 0, 0, 0);
        cycle(0, 0, 0, 2'd0, 0, 0, 0, 0);
        // Reset during a stall with a pending jump: no jump after release.
        cycle(0, 0, 1, 2'd2, 0, 0, 32'h3100, 0);
        cycle(1, 0, 1, 2'd2, 0, 0, 32'h3100, 0);
        cycle(0, 0, 1, 2'd2, 0, 0, 32'h3100, 0);
        cycle(0, 0, 0, 2'd0, 0, 0, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            int r;
            logic [31:0] bt, jt, jrt;
            r   = $urandom_range(0, 99);
            bt  = (r % 2 == 0) ? PCR + ($urandom_range(0, 2047) << 2) : $urandom;
            jt  = PCR + ($urandom_range(0, 4095) << 2);
            jrt = (r % 3 == 0) ? $urandom : PCR + $urandom_range(0, 8191);
            cycle(r < 2, (r >= 2) && (r < 4), $urandom_range(0, 4) == 0,
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), bt, jt, jrt);
        end

        repeat (2) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
